// File: rtl/pipeline_host_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pipeline_host_sequencer
//
// Host-side controller for the pipelined CPU datapath. It drives the
// datapath's three software registers (address, command, write data). A
// valid/ready stream of IMEM/DMEM load words becomes a series of write
// commands, each followed by enough idle cycles for the next write to
// produce a fresh rising edge. After the last word the CPU is enabled for
// a programmed number of cycles. The sequencer then waits for the pipeline
// to drain and pulses done.
//
// Optional feature macro: SEQ_STEP_EN
//   When defined, the step_mode and step inputs are added. step_mode is
//   latched with start. With step_mode=1, RUN raises the CPU enable for one
//   cycle on each rising edge of step.
//
// Ports
//   clk, rst            clock (posedge) / asynchronous active-high reset
//   start, run_only     start a sequence; run_only=1 skips the load phase
//   run_cycles          CPU-enable cycles (or steps), latched at start
//   abort               cancel any active phase and return to IDLE
//   load_valid/ready    load word handshake (ready only in LOAD_WAIT)
//   load_target         0 = IMEM word, 1 = DMEM word
//   load_addr/data/last load word contents and end-of-load marker
//   mem_addr_reg        datapath address register
//   mem_cmd_reg         datapath command: bit5 IMEM wr, bit6 DMEM wr,
//                       bit7 cpu_enable
//   mem_data_write_reg  datapath write-data register
//   busy                sequence in progress
//   done / aborted      one-cycle completion / abort pulses
//   run_count           cycles of cpu_enable in this sequence (saturating)
// -----------------------------------------------------------------------------
module pipeline_host_sequencer #(
  parameter int WR_HOLD      = 1,
  parameter int WR_GAP       = 3,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run_only,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic             abort,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             load_target,
  input  logic [31:0]      load_addr,
  input  logic [31:0]      load_data,
  input  logic             load_last,
`ifdef SEQ_STEP_EN
  input  logic             step_mode,
  input  logic             step,
`endif
  output logic [31:0]      mem_addr_reg,
  output logic [31:0]      mem_cmd_reg,
  output logic [31:0]      mem_data_write_reg,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] run_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_WAIT,
    S_WR_ASSERT,
    S_WR_GAP,
    S_FLUSH,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // The hold/gap/drain phases share one down-counter. It is loaded with
  // (length - 1) on entry to a phase, and the phase ends when it reads zero.
  localparam logic [15:0]      HOLD_LOAD  = 16'(WR_HOLD - 1);
  localparam logic [15:0]      GAP_LOAD   = 16'(WR_GAP - 1);
  localparam logic [15:0]      DRAIN_LOAD = 16'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ALL    = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0] run_left_q, run_left_d;
  logic [CNT_W-1:0] run_count_q, run_count_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             target_q, target_d;
  logic             last_q, last_d;
  logic             aborted_q, aborted_d;
  logic             cpu_en;

`ifdef SEQ_STEP_EN
  logic step_mode_q, step_mode_d;
  logic step_prev_q;
  logic step_active_q, step_active_d;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      run_left_q  <= '0;
      run_count_q <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      target_q    <= 1'b0;
      last_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_left_q  <= run_left_d;
      run_count_q <= run_count_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      target_q    <= target_d;
      last_q      <= last_d;
      aborted_q   <= aborted_d;
    end
  end

`ifdef SEQ_STEP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_mode_q   <= 1'b0;
      step_prev_q   <= 1'b0;
      step_active_q <= 1'b0;
    end else begin
      step_mode_q   <= step_mode_d;
      step_prev_q   <= step;
      step_active_q <= step_active_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_left_d  = run_left_q;
    run_count_d = run_count_q;
    addr_d      = addr_q;
    data_d      = data_q;
    target_d    = target_q;
    last_d      = last_q;
    aborted_d   = 1'b0;
`ifdef SEQ_STEP_EN
    step_mode_d   = step_mode_q;
    step_active_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          run_left_d  = run_cycles;
          run_count_d = '0;
`ifdef SEQ_STEP_EN
          step_mode_d = step_mode;
`endif
          state_d     = run_only ? S_FLUSH : S_LOAD_WAIT;
        end
      end

      S_LOAD_WAIT: begin
        if (load_valid) begin
          addr_d   = load_addr;
          data_d   = load_data;
          target_d = load_target;
          last_d   = load_last;
          cnt_d    = HOLD_LOAD;
          state_d  = S_WR_ASSERT;
        end
      end

      S_WR_ASSERT: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = GAP_LOAD;
          state_d = S_WR_GAP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_WR_GAP: begin
        if (cnt_q == 16'd0) begin
          state_d = last_q ? S_FLUSH : S_LOAD_WAIT;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_FLUSH: begin
        if (run_left_q == '0) begin
          cnt_d   = DRAIN_LOAD;
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
`ifdef SEQ_STEP_EN
        // A step cycle opens only when no step cycle is active, so an edge
        // that arrives during an active step cycle is ignored.
        if (step_mode_q) begin
          step_active_d = !step_active_q && step && !step_prev_q;
        end
`endif
        if (cpu_en) begin
          if (run_count_q != CNT_ALL) begin
            run_count_d = run_count_q + CNT_ONE;
          end
          run_left_d = run_left_q - CNT_ONE;
          if (run_left_q == CNT_ONE) begin
            cnt_d   = DRAIN_LOAD;
            state_d = S_DRAIN;
`ifdef SEQ_STEP_EN
            step_active_d = 1'b0;
`endif
          end
        end
      end

      S_DRAIN: begin
        if (cnt_q == 16'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort takes priority over everything else. A word that is accepted in
    // the same cycle is latched but is never written, because the sequencer
    // returns to IDLE.
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      aborted_d = 1'b1;
`ifdef SEQ_STEP_EN
      step_active_d = 1'b0;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state, so an asynchronous reset clears
  // them immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
`ifdef SEQ_STEP_EN
    cpu_en = (state_q == S_RUN) && (!step_mode_q || step_active_q);
`else
    cpu_en = (state_q == S_RUN);
`endif
  end

  always_comb begin
    mem_cmd_reg    = '0;
    mem_cmd_reg[5] = (state_q == S_WR_ASSERT) && !target_q;
    mem_cmd_reg[6] = (state_q == S_WR_ASSERT) && target_q;
    mem_cmd_reg[7] = cpu_en;
  end

  assign mem_addr_reg       = addr_q;
  assign mem_data_write_reg = data_q;
  assign load_ready         = (state_q == S_LOAD_WAIT);
  assign busy               = (state_q != S_IDLE);
  assign done               = (state_q == S_DONE);
  assign aborted            = aborted_q;
  assign run_count          = run_count_q;

endmodule

// File: tb/tb_pipeline_host_sequencer.sv
`timescale 1ns/1ps
module tb_pipeline_host_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, run_only, abort;
  logic [31:0] run_cycles;
  logic        load_valid, load_ready, load_target, load_last;
  logic [31:0] load_addr, load_data;
  logic [31:0] mem_addr_reg, mem_cmd_reg, mem_data_write_reg;
  logic        busy, done, aborted;
  logic [31:0] run_count;
`ifdef SEQ_STEP_EN
  logic        step_mode, step;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_host_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .run_only(run_only),
    .run_cycles(run_cycles), .abort(abort),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_target(load_target), .load_addr(load_addr),
    .load_data(load_data), .load_last(load_last),
`ifdef SEQ_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .mem_addr_reg(mem_addr_reg), .mem_cmd_reg(mem_cmd_reg),
    .mem_data_write_reg(mem_data_write_reg),
    .busy(busy), .done(done), .aborted(aborted), .run_count(run_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Run-only vectors. k counts negedges after the edge that accepts start
  // (k=1 is FLUSH). done appears at k = run_cycles + 6, and the enable
  // window is k = 2 .. run_cycles + 1.
  typedef struct {
    logic [31:0] rc;
    int          exp_done_k;
    int          exp_first_en;
    int          exp_last_en;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[4];

  logic [31:0] exp_cmd[1:23];
  logic [31:0] w_addr[3];
  logic [31:0] w_data[3];
  logic        w_tgt[3];
  logic        w_last[3];

  initial begin
    int done_k, first_en, last_en, en_cnt, idx;
    bit pend;

    vecs[0] = '{32'd5, 11, 2, 6, 32'd5};
    vecs[1] = '{32'd0,  6, 0, 0, 32'd0};
    vecs[2] = '{32'd1,  7, 2, 2, 32'd1};
    vecs[3] = '{32'd3,  9, 2, 4, 32'd3};

    for (int k = 1; k <= 23; k++) exp_cmd[k] = 32'h0;
    exp_cmd[2]  = 32'h20;
    exp_cmd[7]  = 32'h20;
    exp_cmd[12] = 32'h40;
    exp_cmd[17] = 32'h80;
    exp_cmd[18] = 32'h80;

    w_addr = '{32'h0, 32'h1, 32'h10};
    w_data = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002};
    w_tgt  = '{1'b0, 1'b0, 1'b1};
    w_last = '{1'b0, 1'b0, 1'b1};

    rst = 1'b1; start = 0; run_only = 0; abort = 0; run_cycles = 0;
    load_valid = 0; load_target = 0; load_addr = 0; load_data = 0; load_last = 0;
`ifdef SEQ_STEP_EN
    step_mode = 0; step = 0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_cmd", mem_cmd_reg, 32'h0);
    check("reset_ready", 32'(load_ready), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_addr", mem_addr_reg, 32'h0);
    check("reset_runcount", run_count, 32'h0);
    $display("txn reset: busy=%0d cmd=%h", busy, mem_cmd_reg);

    // Load sequence: two IMEM words and one final DMEM word, then 2 run cycles
    idx = 0; pend = 0;
    load_valid = 1; load_addr = w_addr[0]; load_data = w_data[0];
    load_target = w_tgt[0]; load_last = w_last[0];
    start = 1; run_only = 0; run_cycles = 32'd2;
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      start = 0;
      check($sformatf("load_cmd_k%0d", k), mem_cmd_reg, exp_cmd[k]);
      check($sformatf("load_ready_k%0d", k), 32'(load_ready), 32'((k == 1) || (k == 6) || (k == 11)));
      if (mem_cmd_reg[5] && mem_cmd_reg[7]) check("bit5_bit7_overlap", 32'd1, 32'd0);
      if (k == 2 || k == 7 || k == 12) begin
        check($sformatf("load_addr_k%0d", k), mem_addr_reg, w_addr[(k - 2) / 5]);
        check($sformatf("load_data_k%0d", k), mem_data_write_reg, w_data[(k - 2) / 5]);
      end
      if (k == 23) check("load_done", 32'(done), 32'd1);
      if (pend) begin
        idx++; pend = 0;
        if (idx < 3) begin
          load_addr = w_addr[idx]; load_data = w_data[idx];
          load_target = w_tgt[idx]; load_last = w_last[idx];
        end else begin
          load_valid = 0;
        end
      end
      if (load_ready && load_valid) pend = 1;
    end
    check("load_runcount", run_count, 32'd2);
    $display("txn load: words=%0d run_count=%0d", idx, run_count);
    @(negedge clk);
    check("load_idle", 32'(busy), 32'd0);

    // Abort during WR_ASSERT
    load_valid = 1; load_addr = 32'h5; load_data = 32'h55; load_target = 0; load_last = 0;
    start = 1; run_only = 0;
    @(negedge clk); start = 0;             // k=1 LOAD_WAIT
    @(negedge clk);                        // k=2 WR_ASSERT
    check("abort_wr_cmd", mem_cmd_reg, 32'h20);
    abort = 1;
    @(negedge clk);
    abort = 0; load_valid = 0;
    check("abort_cmd", mem_cmd_reg, 32'h0);
    check("abort_pulse", 32'(aborted), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    check("abort_pulse_end", 32'(aborted), 32'd0);
    $display("txn abort: aborted=%0d busy=%0d", aborted, busy);

    // Table-driven run-only sequences
    for (int v = 0; v < 4; v++) begin
      done_k = 0; first_en = 0; last_en = 0; en_cnt = 0;
      start = 1; run_only = 1; run_cycles = vecs[v].rc;
      for (int k = 1; k <= 60; k++) begin
        @(negedge clk);
        start = 0;
        if (mem_cmd_reg[7]) begin
          if (first_en == 0) first_en = k;
          last_en = k;
          en_cnt++;
        end
        if (load_ready) check("run_ready", 32'(load_ready), 32'd0);
        if (done) begin
          done_k = k;
          check("run_done_busy", 32'(busy), 32'd1);
          break;
        end
      end
      if (done_k == 0) check($sformatf("run_v%0d_timeout", v), 32'd0, 32'd1);
      check($sformatf("run_v%0d_done_k", v), 32'(done_k), 32'(vecs[v].exp_done_k));
      check($sformatf("run_v%0d_en_cnt", v), 32'(en_cnt), vecs[v].rc);
      check($sformatf("run_v%0d_first", v), 32'(first_en), 32'(vecs[v].exp_first_en));
      check($sformatf("run_v%0d_last", v), 32'(last_en), 32'(vecs[v].exp_last_en));
      check($sformatf("run_v%0d_count", v), run_count, vecs[v].exp_cnt);
      @(negedge clk);
      check($sformatf("run_v%0d_idle", v), 32'(busy), 32'd0);
      check($sformatf("run_v%0d_hold", v), run_count, vecs[v].exp_cnt);
      $display("txn run rc=%0d: done_k=%0d en=%0d run_count=%0d", vecs[v].rc, done_k, en_cnt, run_count);
    end

`ifdef SEQ_STEP_EN
    // Step mode: three step pulses 10 cycles apart
    done_k = 0; en_cnt = 0;
    start = 1; run_only = 1; run_cycles = 32'd3; step_mode = 1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      start = 0;
      if (mem_cmd_reg[7]) en_cnt++;
      if (done) begin done_k = k; break; end
      step = (k == 5) || (k == 15) || (k == 25);
    end
    step = 0; step_mode = 0;
    check("step_done_seen", 32'(done_k != 0), 32'd1);
    check("step_en_cnt", 32'(en_cnt), 32'd3);
    check("step_count", run_count, 32'd3);
    $display("txn step: en=%0d done_k=%0d", en_cnt, done_k);
    @(negedge clk);
`endif

    // Asynchronous reset in the middle of RUN
    start = 1; run_only = 1; run_cycles = 32'd20;
    repeat (5) begin
      @(negedge clk);
      start = 0;
    end
    check("midrun_cmd", mem_cmd_reg, 32'h80);
    #2 rst = 1'b1;
    #1;
    check("rst_cmd", mem_cmd_reg, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_runcount", run_count, 32'h0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_stay_idle", 32'(busy), 32'd0);
    $display("txn async_reset: busy=%0d cmd=%h", busy, mem_cmd_reg);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
